// File: rtl/code_sequence_tx.sv
// Serial unlock-code transmitter: one-cycle pulses on zero_out/one_out with a
// start/busy/done handshake. Define TX_REPEAT_EN to keep repeating rounds while start is held.
module code_sequence_tx #(
    parameter int                  CODE_LEN   = 5,
    parameter logic [CODE_LEN-1:0] CODE       = 5'b11011,
    parameter int                  GAP_CYCLES = 1
) (
    input  logic       clk_1hz,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       zero_out,
    output logic       one_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] sent_cnt,
    output logic [7:0] seg7
);

    localparam logic [2:0] LEN3 = 3'(CODE_LEN);
    localparam logic [3:0] GAP4 = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_start_q;
    logic [CODE_LEN-1:0] r_shift;
    logic [3:0]          r_gap_cnt;
    logic                r_zero;
    logic                r_one;
    logic                r_busy;
    logic                r_done;
    logic [2:0]          r_sent;

    state_t              w_state;
    logic [CODE_LEN-1:0] w_shift;
    logic [3:0]          w_gap_cnt;
    logic                w_zero;
    logic                w_one;
    logic                w_busy;
    logic                w_done;
    logic [2:0]          w_sent;
    logic [2:0]          w_sent_inc;
    logic                w_start_pulse;

    assign w_start_pulse = start & ~r_start_q;
    assign w_sent_inc    = r_sent + 3'd1;

    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_shift   <= '0;
            r_gap_cnt <= 4'd0;
            r_zero    <= 1'b0;
            r_one     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sent    <= 3'd0;
        end else begin
            r_state   <= w_state;
            r_start_q <= start;
            r_shift   <= w_shift;
            r_gap_cnt <= w_gap_cnt;
            r_zero    <= w_zero;
            r_one     <= w_one;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_sent    <= w_sent;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_gap_cnt = r_gap_cnt;
        w_zero    = 1'b0;
        w_one     = 1'b0;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_sent    = r_sent;

        // Abort cancels any active phase, including the done cycle; sent_cnt is kept for display.
        if (abort && (r_state != S_IDLE)) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_busy = 1'b0;
                    if (w_start_pulse) begin
                        w_shift = CODE;
                        w_sent  = 3'd0;
                        w_busy  = 1'b1;
                        w_state = S_SEND;
                    end
                end
                S_SEND: begin
                    w_one   = r_shift[CODE_LEN-1];
                    w_zero  = ~r_shift[CODE_LEN-1];
                    w_shift = r_shift << 1;
                    w_sent  = w_sent_inc;
                    if (GAP_CYCLES > 0) begin
                        w_gap_cnt = GAP4 - 4'd1;
                        w_state   = S_GAP;
                    end else if (w_sent_inc == LEN3) begin
                        w_state = S_DONE;
                    end else begin
                        w_state = S_SEND;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        w_state = (r_sent == LEN3) ? S_DONE : S_SEND;
                    end else begin
                        w_gap_cnt = r_gap_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
`ifdef TX_REPEAT_EN
                    if (start) begin
                        w_shift = CODE;
                        w_sent  = 3'd0;
                        w_busy  = 1'b1;
                        w_state = S_SEND;
                    end
`endif
                end
                default: begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end
            endcase
        end
    end

    assign zero_out = r_zero;
    assign one_out  = r_one;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sent_cnt = r_sent;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp bit held at 0.
    always_comb begin
        seg7 = 8'h40;
        case (r_sent)
            3'd0:    seg7 = 8'h40;
            3'd1:    seg7 = 8'h79;
            3'd2:    seg7 = 8'h24;
            3'd3:    seg7 = 8'h30;
            3'd4:    seg7 = 8'h19;
            3'd5:    seg7 = 8'h12;
            3'd6:    seg7 = 8'h02;
            3'd7:    seg7 = 8'h78;
            default: seg7 = 8'h40;
        endcase
    end

endmodule

// File: tb/tb_code_sequence_tx.sv
// Bench for code_sequence_tx: two configurations (gap 1 and gap 0) driven by the
// same stimulus, compared every cycle against a timeline model of the transmission.
module tb_code_sequence_tx;

    logic clk_1hz = 1'b0;
    logic reset, start, abort;
    logic z0, o0, b0, d0, z1, o1, b1, d1;
    logic [2:0] s0, s1;
    logic [7:0] g0, g1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef TX_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    code_sequence_tx #(.CODE_LEN(5), .CODE(5'b11011), .GAP_CYCLES(1)) dut0 (
        .clk_1hz(clk_1hz), .reset(reset), .start(start), .abort(abort),
        .zero_out(z0), .one_out(o0), .busy(b0), .done(d0), .sent_cnt(s0), .seg7(g0)
    );

    code_sequence_tx #(.CODE_LEN(5), .CODE(5'b11011), .GAP_CYCLES(0)) dut1 (
        .clk_1hz(clk_1hz), .reset(reset), .start(start), .abort(abort),
        .zero_out(z1), .one_out(o1), .busy(b1), .done(d1), .sent_cnt(s1), .seg7(g1)
    );

    always #5 clk_1hz = ~clk_1hz;

    // Model: each configuration is a timeline counted from the accepted start edge.
    int         L[2]     = '{5, 5};
    int         G[2]     = '{1, 0};
    logic [6:0] CODEV[2] = '{7'b0011011, 7'b0011011};
    logic [7:0] SEG[8]   = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78};

    bit act[2];
    int n[2];
    int m_sent[2];
    bit m_zero[2], m_one[2], m_busy[2], m_done[2];
    bit prev_start;

    task automatic model_reset();
        prev_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; n[i] = 0; m_sent[i] = 0;
            m_zero[i] = 0; m_one[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit sp;
        sp = start & ~prev_start;
        prev_start = start;
        for (int i = 0; i < 2; i++) begin
            int per;
            int tdone;
            per   = G[i] + 1;
            tdone = 1 + L[i] * per;
            m_zero[i] = 0; m_one[i] = 0; m_done[i] = 0;
            if (act[i]) begin
                if (abort) begin
                    act[i] = 0;
                    m_busy[i] = 0;
                end else begin
                    n[i]++;
                    if (n[i] == tdone) begin
                        m_done[i] = 1; m_busy[i] = 0; act[i] = 0;
                        if (REP && start) begin
                            act[i] = 1; n[i] = 0; m_sent[i] = 0; m_busy[i] = 1;
                        end
                    end else if ((n[i] - 1) % per == 0) begin
                        int k;
                        bit b;
                        k = (n[i] - 1) / per;
                        b = CODEV[i][L[i] - 1 - k];
                        m_one[i] = b; m_zero[i] = !b; m_sent[i] = k + 1;
                    end
                end
            end else if (sp) begin
                act[i] = 1; n[i] = 0; m_sent[i] = 0; m_busy[i] = 1;
            end
        end
    endtask

    task automatic check(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic [14:0] got;
            logic [14:0] exp;
            got = (i == 0) ? {z0, o0, b0, d0, s0, g0} : {z1, o1, b1, d1, s1, g1};
            exp = {m_zero[i], m_one[i], m_busy[i], m_done[i], 3'(m_sent[i]), SEG[m_sent[i]]};
            total++;
            assert (got === exp) else begin
                bad++;
                $error("FAIL %s dut%0d cyc=%0d {z,o,busy,done,cnt,seg} got=%h exp=%h",
                       tag, i, cyc, got, exp);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_1hz);
        model_edge();
        cyc++;
        #1;
        check(tag);
    endtask

    // Reset pulse between edges, checked while still asserted.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check(tag);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_1hz);
        #1;
        check("reset_state");
        reset = 1'b0;
        step("idle"); step("idle");

        // Single start pulse: full code on both configurations.
        start = 1'b1; step("basic_e0");
        start = 1'b0;
        repeat (13) step("basic");
        check_val("basic_cnt", {5'd0, s0}, 8'd5);
        check_val("basic_seg", g0, 8'h12);

        // Second rising edge of start at E4 while busy is ignored.
        start = 1'b1; step("restart_e0");
        start = 1'b0; repeat (3) step("restart");
        start = 1'b1; step("restart_e4");
        start = 1'b0; repeat (10) step("restart");

        // Abort during the cycle after E5.
        start = 1'b1; step("abort_e0");
        start = 1'b0; repeat (5) step("abort_run");
        abort = 1'b1; step("abort_e6");
        abort = 1'b0;
        check_val("abort_cnt", {5'd0, s0}, 8'd3);
        check_val("abort_seg", g0, 8'h30);
        check_val("abort_busy", {7'd0, b0}, 8'd0);
        repeat (3) step("abort_idle");
        start = 1'b1; step("after_abort_e0");
        start = 1'b0; repeat (13) step("after_abort");

        // Abort and start together in IDLE: start wins.
        start = 1'b1; abort = 1'b1; step("abort_start_idle");
        start = 1'b0; abort = 1'b0; repeat (12) step("abort_start_run");

        // Reset between E6 and E7.
        start = 1'b1; step("rst_e0");
        start = 1'b0; repeat (6) step("rst_run");
        do_reset("rst_mid");
        check_val("rst_seg", g0, 8'h40);
        repeat (4) step("rst_after");

        // Start held high: repeated rounds only when the repeat feature is built in.
        start = 1'b1; repeat (30) step("hold");
        start = 1'b0; repeat (14) step("hold_release");

        // Randomized start/abort/reset traffic.
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 3) == 0) start = ~start;
            abort = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            step("rand");
        end
        start = 1'b0; abort = 1'b0;
        repeat (14) step("drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
